// File: rtl/register_bank.sv
// Register bank: 2**ADDR_W words, one write port, two combinational read ports.
// Optional hardwired-zero word 0 and optional write-through bypass on reads.
module register_bank #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     WE,
    input  logic [ADDR_W-1:0]        WA,
    input  logic [DATA_W-1:0]        WD,
    input  logic [ADDR_W-1:0]        RA1,
    input  logic [ADDR_W-1:0]        RA2,
    output logic [DATA_W-1:0]        RD1,
    output logic [DATA_W-1:0]        RD2,
    output logic [(2**ADDR_W)-1:0]   WE_OH
);

    localparam int NWORDS = 2**ADDR_W;

    logic [NWORDS-1:0] strobe;
    logic [DATA_W-1:0] mem [NWORDS];

    // Enabled one-hot decode; reset suppresses the strobe so a write in a reset cycle is dropped.
    always_comb begin
        strobe = '0;
        if (WE && !RST)
            strobe[WA] = 1'b1;
        if (ZERO_REG != 0)
            strobe[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < NWORDS; k++)
                mem[k] <= '0;
            WE_OH <= '0;
        end else begin
            for (int k = 0; k < NWORDS; k++)
                if (strobe[k])
                    mem[k] <= WD;
            WE_OH <= strobe;
        end
    end

    // Override order: reset, then hardwired zero, then bypass, then storage.
    function automatic logic [DATA_W-1:0] read_port(
        input logic              rst,
        input logic              we,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd,
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] stored
    );
        if (rst)
            return '0;
        if (ZERO_REG != 0 && ra == '0)
            return '0;
        if (BYPASS != 0 && we && ra == wa)
            return wd;
        return stored;
    endfunction

    always_comb RD1 = read_port(RST, WE, WA, WD, RA1, mem[RA1]);
    always_comb RD2 = read_port(RST, WE, WA, WD, RA2, mem[RA2]);

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: a bypass and a non-bypass bank share stimulus,
// plus a narrow ADDR_W=3/DATA_W=8 instance without the zero register.
module tb_register_bank;

    logic        CLK = 1'b0;
    logic        rst, we;
    logic [4:0]  wa, ra1, ra2;
    logic [31:0] wd;
    logic [31:0] b_rd1, b_rd2, n_rd1, n_rd2, b_oh, n_oh;

    logic        s_rst, s_we;
    logic [2:0]  s_wa, s_ra1, s_ra2;
    logic [7:0]  s_wd, s_rd1, s_rd2, s_oh;

    int total = 0;
    int passed = 0;

    always #5 CLK = ~CLK;

    register_bank dut (
        .CLK(CLK), .RST(rst), .WE(we), .WA(wa), .WD(wd), .RA1(ra1), .RA2(ra2),
        .RD1(b_rd1), .RD2(b_rd2), .WE_OH(b_oh)
    );

    register_bank #(.BYPASS(0)) dut_nb (
        .CLK(CLK), .RST(rst), .WE(we), .WA(wa), .WD(wd), .RA1(ra1), .RA2(ra2),
        .RD1(n_rd1), .RD2(n_rd2), .WE_OH(n_oh)
    );

    register_bank #(.ADDR_W(3), .DATA_W(8), .ZERO_REG(0)) dut_s (
        .CLK(CLK), .RST(s_rst), .WE(s_we), .WA(s_wa), .WD(s_wd), .RA1(s_ra1), .RA2(s_ra2),
        .RD1(s_rd1), .RD2(s_rd2), .WE_OH(s_oh)
    );

    typedef struct {
        logic        rst, we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1, ra2;
        logic [31:0] b1, b2, n1, n2;  // pre-edge reads: bypass bank, non-bypass bank
        logic [31:0] oh;              // WE_OH after the edge (both banks)
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(
        input logic rst_i, we_i, input logic [4:0] wa_i, input logic [31:0] wd_i,
        input logic [4:0] ra1_i, ra2_i, input logic [31:0] b1_i, b2_i, n1_i, n2_i, oh_i
    );
        vec_t v;
        v.rst = rst_i; v.we = we_i; v.wa = wa_i; v.wd = wd_i; v.ra1 = ra1_i; v.ra2 = ra2_i;
        v.b1 = b1_i; v.b2 = b2_i; v.n1 = n1_i; v.n2 = n2_i; v.oh = oh_i;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    initial begin
        //             rst  we  wa  wd            ra1 ra2  b1            b2            n1            n2            oh
        vecs[0]  = mk(1'b1,1'b0, 0, 32'h0,         0,  0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0);
        vecs[1]  = mk(1'b0,1'b1, 7, 32'hDEADBEEF,  7,  0, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        32'h80);
        vecs[2]  = mk(1'b1,1'b0, 0, 32'h0,         7,  7, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0);
        vecs[3]  = mk(1'b0,1'b0, 0, 32'h0,         7,  7, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0);
        vecs[4]  = mk(1'b1,1'b1, 3, 32'h55,        3,  3, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0);
        vecs[5]  = mk(1'b0,1'b0, 0, 32'h0,         3,  3, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0);
        vecs[6]  = mk(1'b0,1'b1, 0, 32'hFFFFFFFF,  0,  0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0);
        vecs[7]  = mk(1'b0,1'b0, 0, 32'h0,         0,  0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0);
        vecs[8]  = mk(1'b0,1'b1, 5, 32'h11,        5,  6, 32'h11,       32'h0,        32'h0,        32'h0,        32'h20);
        vecs[9]  = mk(1'b0,1'b1, 5, 32'h22,        5,  5, 32'h22,       32'h22,       32'h11,       32'h11,       32'h20);
        vecs[10] = mk(1'b0,1'b0, 0, 32'h0,         5,  5, 32'h22,       32'h22,       32'h22,       32'h22,       32'h0);
        vecs[11] = mk(1'b0,1'b1, 9, 32'hA5A5A5A5,  9,  9, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        32'h0,        32'h200);
        vecs[12] = mk(1'b0,1'b1,10, 32'h12345678,  9, 10, 32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5, 32'h0,        32'h400);
        vecs[13] = mk(1'b0,1'b0, 0, 32'h0,         9, 10, 32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5, 32'h12345678, 32'h0);
        vecs[14] = mk(1'b0,1'b1, 3, 32'hCAFEF00D,  3,  5, 32'hCAFEF00D, 32'h22,       32'h0,        32'h22,       32'h8);
        vecs[15] = mk(1'b0,1'b0, 0, 32'h0,         3,  0, 32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 32'h0,        32'h0);

        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
        s_rst = 1'b1; s_we = 1'b0; s_wa = '0; s_wd = '0; s_ra1 = '0; s_ra2 = '0;

        foreach (vecs[i]) begin
            @(negedge CLK);
            rst = vecs[i].rst; we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
            ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
            #1;
            chk($sformatf("v%0d b_rd1", i), b_rd1, vecs[i].b1);
            chk($sformatf("v%0d b_rd2", i), b_rd2, vecs[i].b2);
            chk($sformatf("v%0d n_rd1", i), n_rd1, vecs[i].n1);
            chk($sformatf("v%0d n_rd2", i), n_rd2, vecs[i].n2);
            @(posedge CLK); #1;
            chk($sformatf("v%0d b_oh", i), b_oh, vecs[i].oh);
            chk($sformatf("v%0d n_oh", i), n_oh, vecs[i].oh);
            if (i == 6) begin
                // zero register still reads 0 after the attempted write edge
                chk("zero post b_rd1", b_rd1, 32'h0);
                chk("zero post n_rd2", n_rd2, 32'h0);
            end
            if (i == 9)
                chk("nobypass post n_rd1", n_rd1, 32'h22);
        end

        // Write every word, then read it back on both ports.
        for (int k = 0; k < 32; k++) begin
            logic [31:0] val, exp_rd, exp_oh;
            val    = k * 32'h01010101;
            exp_rd = (k == 0) ? 32'h0 : val;
            exp_oh = (k == 0) ? 32'h0 : (32'h1 << k);
            @(negedge CLK);
            rst = 1'b0; we = 1'b1; wa = k[4:0]; wd = val; ra1 = k[4:0]; ra2 = k[4:0];
            @(posedge CLK); #1;
            chk($sformatf("all%0d b_oh", k), b_oh, exp_oh);
            chk($sformatf("all%0d n_oh", k), n_oh, exp_oh);
            @(negedge CLK);
            we = 1'b0;
            #1;
            chk($sformatf("all%0d b_rd1", k), b_rd1, exp_rd);
            chk($sformatf("all%0d b_rd2", k), b_rd2, exp_rd);
            chk($sformatf("all%0d n_rd1", k), n_rd1, exp_rd);
            chk($sformatf("all%0d n_rd2", k), n_rd2, exp_rd);
        end

        // Narrow instance: word 0 is an ordinary register there.
        @(negedge CLK);
        s_rst = 1'b0; s_we = 1'b1; s_wa = 3'd0; s_wd = 8'h7F; s_ra1 = 3'd0; s_ra2 = 3'd1;
        #1;
        chk("sweep bypass rd1", {24'h0, s_rd1}, 32'h7F);
        chk("sweep rd2 other", {24'h0, s_rd2}, 32'h0);
        @(posedge CLK); #1;
        chk("sweep oh", {24'h0, s_oh}, 32'h01);
        @(negedge CLK);
        s_we = 1'b1; s_wa = 3'd7; s_wd = 8'hA5; s_ra2 = 3'd0;
        @(posedge CLK); #1;
        chk("sweep oh top", {24'h0, s_oh}, 32'h80);
        @(negedge CLK);
        s_we = 1'b0; s_ra1 = 3'd7;
        #1;
        chk("sweep rd1 w7", {24'h0, s_rd1}, 32'hA5);
        chk("sweep rd2 w0", {24'h0, s_rd2}, 32'h7F);
        @(posedge CLK); #1;
        chk("sweep oh idle", {24'h0, s_oh}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
